// File: rtl/bin_to_digits.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding a 3-digit 7-segment driver.
// Optional leading-zero blanking is enabled by defining the macro LZB_EN.
module bin_to_digits #(
    parameter int         W          = 10,
    parameter logic [4:0] BLANK_CODE = 5'h10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [4:0]   u,
    output logic [4:0]   d,
    output logic [4:0]   c,
    output logic [1:0]   state_dbg
);

    // Handshake: start is a request that is taken on a rising edge only while
    // busy=0; busy then stays high until the edge that raises done for one cycle,
    // so a start held in the done cycle is accepted (busy has already dropped).

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] shreg;
    logic [11:0]  bcd;
    logic         thou;
    logic [3:0]   cnt;

    logic [11:0]  bcd_adj;
    logic [4:0]   u_nxt;
    logic [4:0]   d_nxt;
    logic [4:0]   c_nxt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign bcd_adj   = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign state_dbg = state;

    always_comb begin
        u_nxt = {1'b0, bcd[3:0]};
        d_nxt = {1'b0, bcd[7:4]};
        c_nxt = {1'b0, bcd[11:8]};
`ifdef LZB_EN
        if (bcd[11:8] == 4'd0) begin
            c_nxt = BLANK_CODE;
            if (bcd[7:4] == 4'd0) begin
                d_nxt = BLANK_CODE;
            end
        end
`endif
        // Overflow display wins over blanking.
        if (thou) begin
            u_nxt = 5'd9;
            d_nxt = 5'd9;
            c_nxt = 5'd9;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            bcd   <= '0;
            thou  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            u     <= 5'd0;
            d     <= 5'd0;
            c     <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bin;
                        bcd   <= '0;
                        thou  <= 1'b0;
                        cnt   <= 4'(W);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A bit leaving the hundreds nibble means the value reached 1000;
                    // it is kept sticky only as the overflow flag.
                    bcd   <= {bcd_adj[10:0], shreg[W-1]};
                    thou  <= thou | bcd_adj[11];
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    u     <= u_nxt;
                    d     <= d_nxt;
                    c     <= c_nxt;
                    ovf   <= thou;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_digits.sv
// Scoreboard bench for bin_to_digits: random and directed values against a decimal-arithmetic model.
module tb_bin_to_digits;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] bin;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [4:0]   u;
    logic [4:0]   d;
    logic [4:0]   c;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_run = 0;

    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [15:0] last_out = '0;

    bin_to_digits #(.W(W), .BLANK_CODE(5'h10)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .u(u), .d(d), .c(c), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // reference model: {ovf, c, d, u}
    function automatic logic [15:0] model(input int v);
        int cc, dd, uu;
        logic [4:0] c5, d5, u5;
        if (v > 999) return {1'b1, 5'd9, 5'd9, 5'd9};
        cc = v / 100;
        dd = (v / 10) % 10;
        uu = v % 10;
        c5 = 5'(cc);
        d5 = 5'(dd);
        u5 = 5'(uu);
`ifdef LZB_EN
        if (cc == 0) c5 = 5'h10;
        if (cc == 0 && dd == 0) d5 = 5'h10;
`endif
        return {1'b0, c5, d5, u5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [15:0] e;
        int a;
        if (rst) begin
            last_out = '0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check("busy_at_done", 32'(busy), 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("digits_ovf_c_d_u", 32'({ovf, c, d, u}), 32'(e));
                    check("latency", 32'(cyc - a), 32'(W + 1));
                    check("busy_cycles", 32'(busy_run), 32'(W + 1));
                    last_out = e;
                end
                busy_run = 0;
            end else begin
                check("hold_outputs", 32'({ovf, c, d, u}), 32'(last_out));
            end
        end
    end

    // driver tasks
    task automatic issue(input int v);
        start = 1'b1;
        bin   = W'(v);
        exp_q.push_back(model(v));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = W'($urandom_range(0, 1023));
    endtask

    task automatic convert(input int v);
        int g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_not_busy: got busy=1 expected 0 within 100 cycles");
        end else begin
            issue(v);
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got pending=%0d expected 0 within 200 cycles", exp_q.size());
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_u"}, 32'(u), 32'd0);
        check({tag, "_d"}, 32'(d), 32'd0);
        check({tag, "_c"}, 32'(c), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // basic conversion, outputs hold while bin moves
        convert(357);
        wait_idle();
        bin = '0;
        repeat (5) @(negedge clk);

        // boundaries, back to back
        convert(0);
        convert(999);
        convert(1000);
        convert(1023);
        wait_idle();

        // start while busy is ignored
        convert(128);
        repeat (2) @(negedge clk);
        check("busy_at_plus3", 32'(busy), 32'd1);
        start = 1'b1;
        bin   = 10'd42;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_at_plus7", 32'(busy), 32'd1);
        start = 1'b1;
        bin   = 10'd42;
        @(negedge clk);
        start = 1'b0;
        // start in the done cycle is accepted
        wait_done();
        issue(42);
        wait_idle();

        // reset mid-conversion
        convert(500);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        convert(61);
        wait_idle();

        // blanking-related values (plain digits without LZB_EN)
        convert(7);
        convert(40);
        convert(305);
        convert(0);
        wait_idle();

        // random stimulus with random gaps
        for (int i = 0; i < 40; i++) begin
            convert(int'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_digits.md
Name: bin_to_digits

Overview:
Sequential binary-to-decimal converter that feeds the three-digit 7-segment display driver directly upstream. Accepts an unsigned binary value on a start strobe and converts it with shift-add-3 (double dabble), one bit per clock. Presents units/tens/hundreds as registered 5-bit digit codes u, d, c, which connect straight to the driver's digit inputs. Outputs hold the last result between conversions, so the display never shows intermediate values.

Parameters:
W, 10, input width in bits; legal range 4..10.
BLANK_CODE, 5'h10, digit code emitted for a blanked digit (used only with LZB_EN).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request; sampled only when busy=0
bin  input  W  unsigned value; latched on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new u/d/c are valid
ovf  output  1  latched value exceeded 999; updated with each done
u  output  5  units digit code, 0..9 in bits [3:0], bit 4 = 0
d  output  5  tens digit code
c  output  5  hundreds digit code

Behaviour:
- Reset (async, rst=1): state=IDLE; u=d=c=5'd0; busy=0; done=0; ovf=0; internal shift and BCD registers cleared. Asserting reset mid-conversion aborts it. No done is generated, and the outputs go to their reset values.
- States: IDLE, SHIFT, FINISH.
- IDLE: if start=1 at edge k, latch bin into the shift register, clear the 12-bit BCD accumulator, set bit counter to W, set busy=1, and go to SHIFT.
- SHIFT, one bit per edge: each BCD nibble >=5 gets +3, then {bcd, shreg} shifts left by 1 and the counter decrements. After W shifts (edges k+1..k+W), go to FINISH.
- FINISH, edge k+W+1:
  - Load u/d/c from the BCD nibbles as {1'b0, nibble}.
  - Set ovf=1 if the latched value >999 (possible only for W=10).
  - On overflow, force u=d=c=5'd9 instead.
  - Assert done=1 for exactly this one cycle, set busy=0, and return to IDLE.
- Latency: start edge to done edge = W+1 clocks (11 for W=10).
- start while busy=1 is ignored and not queued.
- start in the cycle done=1 is accepted (busy already 0), giving back-to-back conversions every W+2 cycles.
- bin changing after the accepted edge has no effect on the running conversion.
- u/d/c/ovf change only at FINISH (or reset) and hold otherwise.
- Thousands carry is discarded and used only for overflow detection. Digit nibbles never exceed 9.

Optional Feature:
Macro LZB_EN (leading-zero blanking).
- With LZB_EN defined, at FINISH:
  - If c digit = 0, output c=BLANK_CODE.
  - If c is blanked and d digit = 0, output d=BLANK_CODE.
  - u is never blanked, so value 0 shows as "  0".
  - Overflow (999) is never blanked.
- Without LZB_EN, leading zeros are output as 5'd0 and BLANK_CODE is unused.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release -> u=d=c=0, busy=0, done=0, ovf=0; no done pulse over 20 idle cycles.
2. Basic conversion, W=10: start with bin=10'd357 -> busy high for 11 cycles, done pulses once at edge +11, c=3, d=5, u=7, ovf=0; outputs hold after bin changes to 0.
3. Boundaries:
   - bin=0 -> c=d=u=0.
   - bin=999 -> c=d=u=9, ovf=0.
   - bin=1000 -> c=d=u=9, ovf=1.
   - bin=1023 -> c=d=u=9, ovf=1.
4. Handshake:
   - start re-asserted with bin=42 at cycles +3 and +7 of a conversion of 128 -> ignored; result is 1/2/8.
   - start in the done cycle with bin=42 -> accepted; second done 11 cycles later with 0/4/2.
5. Reset mid-operation: start bin=500, assert rst at cycle +5 -> no done; outputs 0; a fresh start of 61 after release yields 0/6/1.
6. LZB_EN defined:
   - bin=7 -> c=d=5'h10, u=7.
   - bin=40 -> c=5'h10, d=4, u=0.
   - bin=305 -> c=3, d=0, u=5.
   - bin=0 -> c=d=5'h10, u=0.
